// File: rtl/sample_buffer.sv
// Capture buffer: circular RAM written while armed, post-trigger countdown, then newest-first readout.
// Optional pre-trigger fill gating is compiled in with `define SAMPLE_BUFFER_PREFILL_EN.
module sample_buffer #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       arm_i,
  input  logic                       abort_i,
  input  logic                       trig_i,
  input  logic                       stb_i,
  input  logic [WORD_BYTES-1:0][7:0] d_i,
  input  logic [CNT_W-1:0]           delay_cnt_i,
  input  logic [CNT_W-1:0]           read_cnt_i,
  output logic                       tx_vld_o,
  input  logic                       tx_rdy_i,
  output logic [WORD_BYTES-1:0][7:0] tx_q_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = WORD_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_POST, S_RD_REQ, S_RD_WAIT, S_PRESENT
  } state_t;

  // tx handshake: tx_vld_o rises with tx_q_o and both hold until a cycle with tx_rdy_i=1.
  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [W-1:0]    tx_q_q, tx_q_d;
  logic            tx_vld_q, tx_vld_d;
  logic            done_q, done_d;
  logic            we, re, enter_rd;
  logic [W-1:0]    mem [DEPTH];
  logic [W-1:0]    ram_rdata_q;
  logic            trig_ok;

`ifdef SAMPLE_BUFFER_PREFILL_EN
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);
  logic [AW:0]      fill_q, fill_d;
  logic [CNT_W-1:0] need;

  // Trigger is held off until the requested pre-trigger history exists.
  always_comb begin
    need    = (rcnt_q > dly_q) ? (rcnt_q - dly_q) : '0;
    trig_ok = (32'(fill_q) >= 32'(need));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fill_q <= '0;
    else       fill_q <= fill_d;
  end
`else
  assign trig_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dly_d    = dly_q;
    rcnt_d   = rcnt_q;
    tx_q_d   = tx_q_q;
    tx_vld_d = tx_vld_q;
    done_d   = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    enter_rd = 1'b0;
`ifdef SAMPLE_BUFFER_PREFILL_EN
    fill_d   = fill_q;
`endif
    if (abort_i) begin
      state_d  = S_IDLE;
      tx_vld_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            dly_d   = delay_cnt_i;
            rcnt_d  = read_cnt_i;
            state_d = S_ARMED;
`ifdef SAMPLE_BUFFER_PREFILL_EN
            fill_d  = '0;
`endif
          end
        end
        S_ARMED: begin
          if (stb_i) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
`ifdef SAMPLE_BUFFER_PREFILL_EN
            if (fill_q != FILL_MAX) fill_d = fill_q + (AW+1)'(1);
`endif
          end
          if (trig_i && trig_ok) begin
            if (dly_q == '0) enter_rd = 1'b1;
            else             state_d  = S_POST;
          end
        end
        S_POST: begin
          if (stb_i) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            dly_d    = dly_q - CNT_W'(1);
            if (dly_q == CNT_W'(1)) enter_rd = 1'b1;
          end
        end
        S_RD_REQ: begin
          re      = 1'b1;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          tx_q_d   = ram_rdata_q;
          tx_vld_d = 1'b1;
          state_d  = S_PRESENT;
        end
        S_PRESENT: begin
          if (tx_rdy_i) begin
            rd_ptr_d = rd_ptr_q - AW'(1);
            rcnt_d   = rcnt_q - CNT_W'(1);
            tx_vld_d = 1'b0;
            if (rcnt_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Newest word is the one just before the (post-write) write pointer.
      if (enter_rd) begin
        rd_ptr_d = wr_ptr_d - AW'(1);
        if (rcnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dly_q    <= '0;
      rcnt_q   <= '0;
      tx_q_q   <= '0;
      tx_vld_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dly_q    <= dly_d;
      rcnt_q   <= rcnt_d;
      tx_q_q   <= tx_q_d;
      tx_vld_q <= tx_vld_d;
      done_q   <= done_d;
    end
  end

  // Capture RAM is not reset.
  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr_q] <= d_i;
    if (re) ram_rdata_q <= mem[rd_ptr_q];
  end

  assign tx_vld_o = tx_vld_q;
  assign tx_q_o   = tx_q_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
endmodule

// File: tb/tb_sample_buffer.sv
// Self-checking bench for sample_buffer (DEPTH=16); expected readout words are queued from a
// small capture-memory model and compared as the DUT presents them.
module tb_sample_buffer;
  localparam int WB    = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int W     = WB * 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             arm_i, abort_i, trig_i, stb_i, tx_rdy_i;
  logic [W-1:0]     d_i;
  logic [CNT_W-1:0] delay_cnt_i, read_cnt_i;
  logic             tx_vld_o, busy_o, done_o;
  logic [W-1:0]     tx_q_o;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem[DEPTH];
  int model_wr = 0;

  sample_buffer #(.WORD_BYTES(WB), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
    .stb_i(stb_i), .d_i(d_i), .delay_cnt_i(delay_cnt_i), .read_cnt_i(read_cnt_i),
    .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i), .tx_q_o(tx_q_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic arm(input int rd, input int dly);
    arm_i       = 1'b1;
    read_cnt_i  = CNT_W'(rd);
    delay_cnt_i = CNT_W'(dly);
    step();
    arm_i = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] data, input logic trig);
    stb_i  = 1'b1;
    d_i    = data;
    trig_i = trig;
    step();
    stb_i  = 1'b0;
    trig_i = 1'b0;
    model_mem[model_wr] = data;
    model_wr = (model_wr + 1) % DEPTH;
  endtask

  task automatic expect_newest(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(model_mem[(((model_wr - 1 - i) % DEPTH) + DEPTH) % DEPTH]);
  endtask

  // scoreboard-driven readout: pops one expectation per presented word
  task automatic read_out(input int n, input int stall_first, input bit junk_stb);
    for (int k = 0; k < n; k++) begin
      int wait_c = 0;
      int stall;
      logic [W-1:0] exp_w;
      logic [W-1:0] held;
      while (tx_vld_o !== 1'b1 && wait_c < 20) begin
        if (junk_stb) begin
          stb_i = 1'b1;
          d_i   = $urandom;
        end
        step();
        wait_c++;
      end
      stb_i = 1'b0;
      checks++;
      if (tx_vld_o !== 1'b1) begin
        $display("FAIL tx_vld_timeout word=%0d got=%b want=1", k, tx_vld_o);
        failures++;
        exp_q.delete();
        return;
      end
      exp_w = exp_q.pop_front();
      checks++;
      if (tx_q_o !== exp_w) begin
        $display("FAIL tx_q word=%0d got=%h want=%h", k, tx_q_o, exp_w);
        failures++;
      end
      held  = tx_q_o;
      stall = (k == 0) ? stall_first : $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        step();
        checks++;
        if (tx_vld_o !== 1'b1 || tx_q_o !== held) begin
          $display("FAIL hold_stable word=%0d cyc=%0d got vld=%b q=%h want vld=1 q=%h",
                   k, s, tx_vld_o, tx_q_o, held);
          failures++;
        end
      end
      checks++;
      if (done_o !== 1'b0) begin
        $display("FAIL done_early word=%0d got=%b want=0", k, done_o);
        failures++;
      end
      tx_rdy_i = 1'b1;
      step();
      tx_rdy_i = 1'b0;
      checks++;
      if (tx_vld_o !== 1'b0) begin
        $display("FAIL vld_after_accept word=%0d got=%b want=0", k, tx_vld_o);
        failures++;
      end
      checks++;
      if (done_o !== logic'(k == n - 1)) begin
        $display("FAIL done_pulse word=%0d got=%b want=%b", k, done_o, logic'(k == n - 1));
        failures++;
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      $display("FAIL busy_end got=%b want=0", busy_o);
      failures++;
    end
    step();
    checks++;
    if (done_o !== 1'b0) begin
      $display("FAIL done_width got=%b want=0", done_o);
      failures++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0; stb_i = 1'b0; tx_rdy_i = 1'b0;
    d_i = '0; delay_cnt_i = '0; read_cnt_i = '0;
    step(); step();
    rst = 1'b0;
    step();
    model_wr = 0;
    checks++;
    if (tx_vld_o !== 1'b0 || tx_q_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("FAIL reset_state got vld=%b q=%h busy=%b done=%b want 0 0 0 0",
               tx_vld_o, tx_q_o, busy_o, done_o);
      failures++;
    end
  endtask

  task automatic test_post_delay();
    arm(4, 2);
    checks++;
    if (busy_o !== 1'b1) begin
      $display("FAIL busy_armed got=%b want=1", busy_o);
      failures++;
    end
    push_word(32'd5, 1'b0);
    push_word(32'd6, 1'b0);
    push_word(32'd7, 1'b1);
    push_word(32'd8, 1'b0);
    push_word(32'd9, 1'b0);
    expect_newest(4);
    read_out(4, 0, 1'b0);
  endtask

  task automatic test_no_delay();
    arm(3, 0);
    arm_i = 1'b1;
    read_cnt_i = CNT_W'(1);
    push_word(32'd1, 1'b0);
    arm_i = 1'b0;
    push_word(32'd2, 1'b0);
    push_word(32'd3, 1'b1);
    expect_newest(3);
    read_out(3, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    arm(2, 0);
    push_word(32'hCAFE_0001, 1'b0);
    push_word(32'hCAFE_0002, 1'b1);
    expect_newest(2);
    read_out(2, 10, 1'b1);
  endtask

  task automatic test_wrap();
    arm(16, 0);
    for (int i = 0; i < 20; i++) push_word(W'(i), logic'(i == 19));
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(19 - i));
    read_out(16, 0, 1'b0);
  endtask

  task automatic test_abort();
    int wait_c = 0;
    arm(3, 0);
    push_word(32'hA1, 1'b0);
    push_word(32'hA2, 1'b1);
    while (tx_vld_o !== 1'b1 && wait_c < 20) begin
      step();
      wait_c++;
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    checks++;
    if (tx_vld_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("FAIL abort_present got vld=%b busy=%b done=%b want 0 0 0",
               tx_vld_o, busy_o, done_o);
      failures++;
    end
    step();
    checks++;
    if (done_o !== 1'b0) begin
      $display("FAIL abort_no_done got=%b want=0", done_o);
      failures++;
    end
    arm(2, 1);
    push_word(32'hB1, 1'b1);
    push_word(32'hB2, 1'b0);
    expect_newest(2);
    read_out(2, 0, 1'b0);
    // a strobe coinciding with abort must not land in the RAM
    arm(3, 0);
    stb_i = 1'b1; d_i = 32'hDEAD_BEEF; abort_i = 1'b1;
    step();
    stb_i = 1'b0; abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      $display("FAIL abort_armed_busy got=%b want=0", busy_o);
      failures++;
    end
    arm(3, 0);
    push_word(32'hC1, 1'b0);
    push_word(32'hC2, 1'b1);
    expect_newest(3);
    read_out(3, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    arm(2, 0);
    push_word(32'h11, 1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if (busy_o !== 1'b0 || tx_vld_o !== 1'b0) begin
      $display("FAIL async_reset got busy=%b vld=%b want 0 0", busy_o, tx_vld_o);
      failures++;
    end
    step();
    rst = 1'b0;
    model_wr = 0;
    step();
    arm(2, 0);
    push_word(32'hE1, 1'b0);
    push_word(32'hE2, 1'b1);
    expect_newest(2);
    read_out(2, 0, 1'b0);
  endtask

`ifdef SAMPLE_BUFFER_PREFILL_EN
  task automatic test_prefill();
    arm(8, 2);
    for (int i = 0; i < 3; i++) push_word(W'(32'h100 + i), 1'b0);
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int i = 3; i < 6; i++) push_word(W'(32'h100 + i), 1'b0);
    checks++;
    if (busy_o !== 1'b1 || tx_vld_o !== 1'b0) begin
      $display("FAIL prefill_hold got busy=%b vld=%b want 1 0", busy_o, tx_vld_o);
      failures++;
    end
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    push_word(32'h106, 1'b0);
    push_word(32'h107, 1'b0);
    expect_newest(8);
    read_out(8, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_post_delay();
    test_no_delay();
    test_backpressure();
    test_wrap();
    test_abort();
    test_mid_reset();
`ifdef SAMPLE_BUFFER_PREFILL_EN
    test_prefill();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_buffer.md
Name: sample_buffer

Overview:
- Capture-memory stage directly downstream of the sample packing cache.
- Consumes packed sample words (stb_i/d_i) into an internal circular RAM while armed, then counts post-trigger words.
- After capture, streams stored words newest-first to the transmitter over a valid/ready handshake.
- Sits between the packing cache and the serial transmit path of the logic analyzer.

Parameters:
- WORD_BYTES, 4, bytes per sample word; equals the packing cache OUTPUT.
- DEPTH, 1024, RAM depth in words; must be a power of two; AW = $clog2(DEPTH).
- CNT_W, 16, width of the read and delay count inputs.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- arm_i  in  1  start capture; sampled only in IDLE
- abort_i  in  1  return to IDLE from any state
- trig_i  in  1  trigger fired, from the trigger stage
- stb_i  in  1  d_i valid; from the packing cache stb_o
- d_i  in  WORD_BYTES*8  packed sample word, byte-array [WORD_BYTES-1:0][7:0]
- delay_cnt_i  in  CNT_W  words to capture after trigger; latched at arm
- read_cnt_i  in  CNT_W  words to transmit; latched at arm
- tx_vld_o  out  1  tx_q_o valid
- tx_rdy_i  in  1  transmitter accepts word
- tx_q_o  out  WORD_BYTES*8  word to transmitter
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at readout completion

Behaviour:
- Reset:
  - State IDLE; wr_ptr = 0, rd_ptr = 0, counters 0.
  - tx_vld_o = 0, tx_q_o = 0, busy_o = 0, done_o = 0.
  - RAM contents are not reset.
- RAM: one write port and one synchronous read port; read data valid one cycle after address issue.
- States: IDLE, ARMED, POST, RD_REQ, RD_WAIT, PRESENT.
- IDLE:
  - stb_i ignored.
  - arm_i=1: latch delay_cnt_i to dly and read_cnt_i to rcnt; wr_ptr keeps its value; go to ARMED.
- ARMED:
  - Each stb_i writes d_i at wr_ptr; wr_ptr increments mod DEPTH (wraps silently).
  - trig_i=1: a stb_i in the same cycle is still written as a pre-trigger word.
    - dly==0: go to RD_REQ.
    - Otherwise: go to POST.
- POST:
  - Each stb_i writes and decrements dly.
  - When the write takes dly from 1 to 0, go to RD_REQ on the next cycle.
  - trig_i is ignored.
- Readout:
  - On entry to RD_REQ from ARMED or POST, rd_ptr = wr_ptr-1 mod DEPTH (newest word first).
  - rcnt==0 on entry: pulse done_o, go to IDLE.
  - RD_REQ: issue RAM read at rd_ptr; go to RD_WAIT.
  - RD_WAIT: register RAM data into tx_q_o; set tx_vld_o=1; go to PRESENT.
  - PRESENT: hold tx_vld_o and tx_q_o stable until tx_rdy_i=1. On acceptance:
    - rd_ptr decrements mod DEPTH; rcnt decrements.
    - If rcnt was 1: tx_vld_o=0, done_o pulses in the same cycle, go to IDLE.
    - Otherwise: tx_vld_o=0, go to RD_REQ.
  - Throughput is at most one word per 3 cycles.
- stb_i in any readout state is ignored; dropped words are not counted.
- read_cnt > DEPTH: rd_ptr wraps and words repeat; no clamping. Unwritten locations return undefined data.
- abort_i:
  - Highest priority after reset; next state IDLE; tx_vld_o=0 next cycle; no done_o pulse.
  - A stb_i in the abort cycle is not written.
- arm_i outside IDLE is ignored.
- Reset asserted mid-capture or mid-readout: immediate return to reset values.

Optional Feature:
- Macro: SAMPLE_BUFFER_PREFILL_EN.
- Defined:
  - ARMED tracks fill, a saturating count of words written since arm, capped at DEPTH.
  - trig_i is ignored until fill >= rcnt - dly, with a saturating subtract at 0.
  - This guarantees the pre-trigger history is fully written before trigger.
- Undefined: no fill counter; trig_i is honoured immediately in ARMED.

Test Plan:
- DEPTH=16, arm rd=4 dly=2; write 5,6,7 (trig with 7), then 8,9 -> POST exits after 9; tx sequence 9,8,7,6; done_o pulses once on the 4th accept.
- dly=0, rd=3; write 1,2,3 with trig on 3 -> no POST writes; tx 3,2,1.
- Hold tx_rdy_i=0 for 10 cycles in PRESENT -> tx_vld_o stays 1 and tx_q_o stays stable; accepted exactly once when tx_rdy_i=1.
- Write 20 words 0..19 into DEPTH=16, trig on 19, dly=0, rd=16 -> tx 19 down to 4; wr_ptr wrap is verified.
- abort_i during PRESENT -> tx_vld_o=0 next cycle, busy_o=0, no done_o; a new arm captures normally.
- PREFILL_EN, rd=8 dly=2; trig pulsed after 3 words -> ignored; trig after 6th word -> accepted; tx yields 8 valid words.
